// File: rtl/thermo_decoder_if.sv
// Bus bundle for thermo_decoder: shift-register feed, thermometer source,
// conversion handshake and decoded result.
interface thermo_decoder_if;
  logic [7:0]   din;
  logic         load_en;
  logic [255:0] thermo_in;
  logic         src_sel;
  logic         conv_start;
  logic         code_ready;
  logic [7:0]   code_out;
  logic         code_valid;
  logic         bubble_err;
  logic         busy;

  modport master (
    output din, load_en, thermo_in, src_sel, conv_start, code_ready,
    input  code_out, code_valid, bubble_err, busy
  );

  modport slave (
    input  din, load_en, thermo_in, src_sel, conv_start, code_ready,
    output code_out, code_valid, bubble_err, busy
  );
endinterface

// File: rtl/thermo_decoder.sv
// Serial 256-bit thermometer-to-binary decoder, one snapshot byte per cycle.
// Optional bubble detection is enabled by defining THERMO_DECODER_BUBBLE_DETECT_EN.
module thermo_decoder (
  input  logic             clk,
  input  logic             rst_n,
  thermo_decoder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;

  state_t       state, state_next;
  logic [255:0] sr;
  logic [255:0] snap;
  logic [8:0]   acc;
  logic [4:0]   beat;
  logic [7:0]   code;
  logic [7:0]   cur_byte;
  logic [3:0]   byte_pop;
  logic [8:0]   sum;
  logic         last_beat;

  // The snapshot is shifted down each beat, so the current byte is always at the bottom
  assign cur_byte  = snap[7:0];
  assign sum       = acc + {5'b0, byte_pop};
  assign last_beat = (beat == 5'd31);

  always_comb begin
    byte_pop = 4'd0;
    for (int i = 0; i < 8; i++) begin
      byte_pop = byte_pop + {3'b0, cur_byte[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.conv_start) state_next = DECODE;
      DECODE:  if (last_beat)      state_next = DONE;
      DONE:    if (bus.code_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr   <= '0;
      snap <= '0;
      acc  <= '0;
      beat <= '0;
      code <= '0;
    end else begin
      if (bus.load_en) sr <= {sr[247:0], bus.din};
      case (state)
        IDLE: begin
          if (bus.conv_start) begin
            snap <= bus.src_sel ? sr : bus.thermo_in;
            acc  <= '0;
            beat <= '0;
          end
        end
        DECODE: begin
          snap <= {8'h00, snap[255:8]};
          acc  <= sum;
          beat <= beat + 5'd1;
          // A full snapshot counts 256, which does not fit the 8-bit result
          if (last_beat) code <= sum[8] ? 8'hFF : sum[7:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.code_out   = code;
  assign bus.code_valid = (state == DONE);
  assign bus.busy       = (state != IDLE);

`ifdef THERMO_DECODER_BUBBLE_DETECT_EN
  logic seen_zero;
  logic bubble;
  logic bubble_err_q;
  logic byte_bubble;

  // Legal byte is 2^n-1; any set bit after an earlier zero byte is also a bubble
  assign byte_bubble = ((cur_byte & (cur_byte + 8'd1)) != 8'h00) ||
                       (seen_zero && (cur_byte != 8'h00));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_zero    <= 1'b0;
      bubble       <= 1'b0;
      bubble_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.conv_start) begin
            seen_zero <= 1'b0;
            bubble    <= 1'b0;
          end
        end
        DECODE: begin
          seen_zero <= seen_zero | (cur_byte != 8'hFF);
          bubble    <= bubble | byte_bubble;
          if (last_beat) bubble_err_q <= bubble | byte_bubble;
        end
        default: ;
      endcase
    end
  end

  assign bus.bubble_err = bubble_err_q;
`else
  assign bus.bubble_err = 1'b0;
`endif

endmodule

// File: tb/tb_thermo_decoder.sv
// Self-checking bench for thermo_decoder: directed vector table, hand-written
// corner sequences and randomized conversions against a popcount/legality model.
module tb_thermo_decoder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  thermo_decoder_if bus();

  thermo_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

`ifdef THERMO_DECODER_BUBBLE_DETECT_EN
  localparam bit BUBBLE_EN = 1'b1;
`else
  localparam bit BUBBLE_EN = 1'b0;
`endif

  typedef struct {
    string        name;
    logic [255:0] thermo;
    int           code;
    logic         bubble;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sr_q[$];
  int         checks   = 0;
  int         failures = 0;

  // The bench's view of the shift register: newest byte first, at most 32 bytes kept
  task automatic tick();
    if (!rst_n) begin
      sr_q.delete();
    end else if (bus.load_en) begin
      sr_q.push_front(bus.din);
      if (sr_q.size() > 32) void'(sr_q.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] ones(input int n);
    logic [255:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [255:0] sr_value();
    logic [255:0] v = '0;
    for (int k = 0; k < sr_q.size(); k++) v[k*8 +: 8] = sr_q[k];
    return v;
  endfunction

  function automatic int model_code(input logic [255:0] s);
    int n = $countones(s);
    return (n > 255) ? 255 : n;
  endfunction

  function automatic logic model_bubble(input logic [255:0] s);
    return BUBBLE_EN && (s != ones($countones(s)));
  endfunction

  function automatic logic [255:0] rand_bits();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic sel, input logic [255:0] th);
    bus.src_sel    = sel;
    bus.thermo_in  = th;
    bus.conv_start = 1'b1;
    tick();
    bus.conv_start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int lat = 0;
    do begin
      tick();
      lat++;
    end while (bus.code_valid !== 1'b1 && lat < 40);
    check_output({name, " latency"}, lat, 32);
  endtask

  task automatic run_conv(input string name, input logic sel, input logic [255:0] th,
                          input int exp_code, input logic exp_bub);
    apply_stimulus(sel, th);
    wait_valid(name);
    check_output({name, " code_out"}, bus.code_out, exp_code);
    check_output({name, " bubble_err"}, bus.bubble_err, exp_bub);
    tick();
    check_output({name, " valid_drop"}, bus.code_valid, 0);
  endtask

  task automatic add_vec(input string name, input logic [255:0] th, input int code,
                         input logic bub);
    vec_t v;
    v.name   = name;
    v.thermo = th;
    v.code   = code;
    v.bubble = bub;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [255:0] th;
    int stable_err;

    bus.din = '0; bus.load_en = 1'b0; bus.thermo_in = '0; bus.src_sel = 1'b0;
    bus.conv_start = 1'b0; bus.code_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check_output("reset code_out", bus.code_out, 0);
    check_output("reset code_valid", bus.code_valid, 0);
    check_output("reset bubble_err", bus.bubble_err, 0);
    check_output("reset busy", bus.busy, 0);

    th = ones(10);
    th[20] = 1'b1;
    add_vec("ones100", ones(100), 100, 1'b0);
    add_vec("zero", '0, 0, 1'b0);
    add_vec("ones10_bit20", th, 11, 1'b1);
    add_vec("all_ones", ones(256), 255, 1'b0);
    add_vec("ones255", ones(255), 255, 1'b0);
    add_vec("ones1", ones(1), 1, 1'b0);
    th = '0;
    th[255] = 1'b1;
    add_vec("top_bit_only", th, 1, 1'b1);
    add_vec("ones8", ones(8), 8, 1'b0);
    add_vec("ones9_gap7", ones(9) & ~ones(8) | ones(7), 8, 1'b1);

    foreach (vecs[i]) begin
      run_conv(vecs[i].name, 1'b0, vecs[i].thermo, vecs[i].code,
               vecs[i].bubble & BUBBLE_EN);
      check_output({vecs[i].name, " busy_idle"}, bus.busy, 0);
    end

    // Shift register filled with 0xFF saturates at 255
    bus.din = 8'hFF;
    bus.load_en = 1'b1;
    repeat (32) tick();
    bus.load_en = 1'b0;
    run_conv("sr_all_ff", 1'b1, '0, 255, 1'b0);

    // Stall in DONE while poking conv_start and thermo_in
    bus.code_ready = 1'b0;
    apply_stimulus(1'b0, ones(40));
    wait_valid("stall");
    check_output("stall code_out", bus.code_out, 40);
    stable_err = 0;
    for (int c = 0; c < 10; c++) begin
      bus.conv_start = ~bus.conv_start;
      bus.thermo_in  = rand_bits();
      tick();
      if (bus.code_out !== 8'd40 || bus.code_valid !== 1'b1) stable_err++;
    end
    check_output("stall hold_errors", stable_err, 0);
    bus.conv_start = 1'b1;
    bus.code_ready = 1'b1;
    tick();
    bus.conv_start = 1'b0;
    check_output("stall exit valid", bus.code_valid, 0);
    check_output("stall exit busy", bus.busy, 0);
    tick();
    check_output("stall no_queued_start", bus.busy, 0);
    check_output("idle retains code_out", bus.code_out, 40);

    // Reset mid-decode, with load_en and conv_start colliding with reset
    bus.din = 8'h3C;
    bus.load_en = 1'b1;
    tick();
    bus.load_en = 1'b0;
    apply_stimulus(1'b0, ones(200));
    repeat (15) tick();
    rst_n = 1'b0;
    bus.load_en = 1'b1;
    bus.conv_start = 1'b1;
    tick();
    rst_n = 1'b1;
    bus.load_en = 1'b0;
    bus.conv_start = 1'b0;
    check_output("midreset busy", bus.busy, 0);
    check_output("midreset code_valid", bus.code_valid, 0);
    check_output("midreset code_out", bus.code_out, 0);
    tick();
    check_output("midreset stays_idle", bus.busy, 0);
    run_conv("sr_after_reset", 1'b1, '0, 0, 1'b0);
    run_conv("after_reset", 1'b0, ones(77), 77, 1'b0);

    // Loads and source changes during a conversion must not disturb it
    apply_stimulus(1'b0, ones(50));
    bus.din = 8'hA5;
    bus.load_en = 1'b1;
    bus.thermo_in = '1;
    bus.src_sel = 1'b1;
    wait_valid("busy_loads");
    bus.load_en = 1'b0;
    check_output("busy_loads code_out", bus.code_out, 50);
    check_output("busy_loads bubble_err", bus.bubble_err, 0);
    tick();
    run_conv("sr_a5", 1'b1, '0, 128, BUBBLE_EN);

    // Randomized conversions against the model
    for (int r = 0; r < 30; r++) begin
      logic [255:0] snap;
      logic sel;
      sel = $urandom_range(0, 1);
      if (sel) begin
        bus.load_en = 1'b1;
        repeat ($urandom_range(0, 40)) begin
          bus.din = 8'($urandom);
          tick();
        end
        bus.load_en = 1'b0;
        snap = sr_value();
        th = rand_bits();
      end else begin
        case ($urandom_range(0, 2))
          0:       th = ones($urandom_range(0, 256));
          1: begin
            th = ones($urandom_range(0, 256));
            th[$urandom_range(0, 255)] ^= 1'b1;
          end
          default: th = rand_bits();
        endcase
        snap = th;
      end
      run_conv($sformatf("rand%0d", r), sel, th, model_code(snap), model_bubble(snap));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/thermo_decoder.md
THERMO_DECODER -- requirements
Module: thermo_decoder

Interface
REQ-001 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port din  input  8  byte for the shift register.
REQ-004 SHALL have port load_en  input  1  shift din into the shift register this cycle.
REQ-005 SHALL have port thermo_in  input  256  parallel thermometer code (bit 0 = LSB level).
REQ-006 SHALL have port src_sel  input  1  0 = thermo_in, 1 = shift register; sampled with conv_start.
REQ-007 SHALL have port conv_start  input  1  start request; honoured only in IDLE.
REQ-008 SHALL have port code_ready  input  1  consumer accepts code_out.
REQ-009 SHALL have port code_out  output  8  decoded level.
REQ-010 SHALL have port code_valid  output  1  code_out and bubble_err valid.
REQ-011 SHALL have port bubble_err  output  1  snapshot was not a legal thermometer code.
REQ-012 SHALL have port busy  output  1  high in LOAD_SNAP-free states DECODE and DONE.

Function
REQ-013 Shift register SHALL update, when load_en=1, to {sr[247:0], din}, independent of FSM state.
REQ-014 FSM SHALL have states IDLE, DECODE, DONE.
REQ-015 IDLE: conv_start=1 SHALL copy selected source into a 256-bit snapshot, clear accumulator, beat index and bubble state, go to DECODE.
REQ-016 DECODE SHALL process one snapshot byte per cycle, byte 0 (bits 7:0) first, 32 beats, adding that byte's popcount to a 9-bit accumulator.
REQ-017 On the 32nd DECODE beat FSM SHALL go to DONE, load code_out and bubble_err, and assert code_valid; code_valid thus rises on the 32nd rising edge after the edge sampling conv_start.
REQ-018 code_out SHALL equal total popcount of the snapshot, saturated: 256 -> 255.
REQ-019 DONE SHALL hold code_out, bubble_err, code_valid stable until an edge with code_ready=1, then return to IDLE with code_valid=0.
REQ-020 code_out and bubble_err SHALL retain their last values in IDLE.
REQ-021 conv_start SHALL be ignored in DECODE and DONE, including the DONE-exit cycle; no request is queued.
REQ-022 Changes to thermo_in, src_sel or shift register after the snapshot SHALL not affect the running conversion.
REQ-023 busy SHALL equal (state != IDLE).

Reset
REQ-024 rst_n=0 at a clock edge SHALL force IDLE, code_out=0, code_valid=0, bubble_err=0, shift register=0, snapshot=0, accumulator=0.
REQ-025 Reset mid-DECODE or in DONE SHALL abort the conversion with no code_valid pulse.
REQ-026 Reset SHALL take priority over load_en and conv_start in the same cycle.

Configuration
REQ-027 Macro THERMO_DECODER_BUBBLE_DETECT_EN SHALL gate bubble detection.
REQ-028 With the macro defined, bubble_err SHALL be 1 iff some snapshot bit i=1 with a bit j<i equal to 0, tracked serially per beat (seen_zero flag across bytes plus in-byte check).
REQ-029 Without the macro, bubble_err SHALL be constant 0 and no detection logic SHALL be synthesised; code_out behaviour unchanged.

Verification
REQ-030 thermo_in = 100 LSB ones, src_sel=0, conv_start pulse, code_ready=1 -> code_valid rises 32 edges after start, code_out=100, bubble_err=0, one-cycle valid.
REQ-031 32 load_en beats of din=8'hFF, src_sel=1, start -> code_out=255 (saturated from 256); all-zero source -> code_out=0, bubble_err=0.
REQ-032 thermo_in = ones in bits 0..9 and bit 20 (macro on) -> code_out=11, bubble_err=1; macro off -> code_out=11, bubble_err=0.
REQ-033 code_ready=0 for 10 cycles in DONE with conv_start pulsed and thermo_in changed -> code_out/code_valid stable, no new conversion; code_ready=1 -> IDLE next edge.
REQ-034 rst_n=0 at DECODE beat 15 -> next cycle IDLE, busy=0, code_valid=0, code_out=0; new start after release yields correct result.
REQ-035 load_en pulses with din=8'hA5 during DECODE -> running result unaffected; following src_sel=1 conversion counts shifted bytes (popcount 4 per 8'hA5 byte, bubble_err=1 with macro).
